// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX FIFO write port
// among NUM_REQ byte-stream requesters, with idle-owner eviction.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_valid_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          timeout_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       own_q, own_d, ptr_q, ptr_d, pick, cand;
    logic                   found;
    logic [15:0]            cnt_q, cnt_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   timeout_q, timeout_d;
    logic                   own_valid, own_last, can_accept, xfer, drain;
    logic [DATA_WIDTH-1:0]  own_data;

    // Handshakes are valid/ready: a beat moves on a cycle where both are high;
    // valid, once raised, holds its data until that beat.
    assign can_accept = (state_q == LOCK) && (!tx_valid_q || tx_ready_i);
    assign xfer       = can_accept && own_valid;
    assign drain      = tx_valid_q && tx_ready_i;

    assign busy_o     = (state_q == LOCK);
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign timeout_o  = timeout_q;

    always_comb begin
        own_valid   = 1'b0;
        own_last    = 1'b0;
        own_data    = '0;
        req_ready_o = '0;
        grant_o     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (own_q == IDX_W'(k)) begin
                own_valid      = req_valid_i[k];
                own_last       = req_last_i[k];
                own_data       = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                req_ready_o[k] = can_accept;
                grant_o[k]     = (state_q == LOCK);
            end
        end
    end

    // Search upward from the requester after the last owner.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (drain) tx_valid_d = 1'b0;
        if (xfer) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i && found) begin
                    state_d = LOCK;
                    own_d   = pick;
                end
            end
            LOCK: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (own_last) begin
                        state_d = IDLE;
                        ptr_d   = own_q;
                    end
                end else if (!own_valid) begin
                    // Stalled-by-FIFO cycles (valid high) leave the count alone.
                    if (cnt_q + 16'd1 == TIMEOUT_W) begin
                        state_d   = IDLE;
                        ptr_d     = own_q;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            own_q      <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message traffic
// checked against a message-level round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   rv, rl;
    logic [N*W-1:0] rd;
    logic           tx_ready;
    logic [N-1:0]   req_ready, grant;
    logic           tx_valid, busy, timeout;
    logic [W-1:0]   tx_data;

    int tests = 0;
    int fails = 0;

    logic [8:0]   src_q[N][$];
    logic [8:0]   mq[N][$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] exp_q[$];
    int           grant_log[$];
    int           exp_grants[$];

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .req_valid_i(rv), .req_data_i(rd), .req_last_i(rl), .req_ready_o(req_ready),
        .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
        .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = '0; rl = '0; rd = '0; en = 1'b1; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requesters present their queued bytes; records granted owners and drained bytes.
    task automatic run_traffic(input int max_cycles, input bit gaps);
        int           cyc;
        int           gap[N];
        logic [N-1:0] acc, mid, prev_g;
        bit           drained, pending;
        logic [W-1:0] dbyte;
        mid = '0; cyc = 0; en = 1'b1; pending = 1'b1; prev_g = grant;
        for (int k = 0; k < N; k++) gap[k] = 0;
        out_q.delete(); grant_log.delete();
        while (pending && cyc < max_cycles) begin
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() == 0) begin
                    rv[k] = 1'b0; rl[k] = 1'b0; rd[k*W +: W] = '0;
                end else if (gaps && mid[k] && gap[k] < 3 && $urandom_range(0, 3) == 0) begin
                    rv[k] = 1'b0; gap[k]++;
                end else begin
                    rv[k] = 1'b1; rl[k] = src_q[k][0][8]; rd[k*W +: W] = src_q[k][0][W-1:0];
                end
            end
            tx_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            acc = rv & req_ready;
            tests++; if ((req_ready & ~grant) !== '0) begin fails++; $display("FAIL ready_non_owner: ready=%b grant=%b", req_ready, grant); end
            tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL traffic_no_timeout: got %b expected 0", timeout); end
            drained = tx_valid && tx_ready;
            dbyte = tx_data;
            if (grant !== '0 && prev_g === '0)
                for (int k = 0; k < N; k++) if (grant[k]) grant_log.push_back(k);
            prev_g = grant;
            tick();
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    mid[k] = !src_q[k][0][8];
                    gap[k] = 0;
                    void'(src_q[k].pop_front());
                end
            end
            if (drained) out_q.push_back(dbyte);
            pending = tx_valid;
            for (int k = 0; k < N; k++) if (src_q[k].size() != 0) pending = 1'b1;
            cyc++;
        end
        rv = '0; rl = '0;
        tests++; if (pending) begin fails++; $display("FAIL traffic_drain: still pending after %0d cycles", cyc); end
    endtask

    // Reference: every requester with messages left is always ready to compete,
    // so whole messages go out in round-robin order starting after requester N-1.
    function automatic void build_model();
        int         ptr, pickk;
        logic [8:0] b;
        exp_q.delete(); exp_grants.delete();
        for (int k = 0; k < N; k++) mq[k] = src_q[k];
        ptr = N - 1;
        pickk = 0;
        while (pickk >= 0) begin
            pickk = -1;
            for (int i = 1; i <= N; i++)
                if (pickk < 0 && mq[(ptr + i) % N].size() > 0) pickk = (ptr + i) % N;
            if (pickk >= 0) begin
                exp_grants.push_back(pickk);
                do begin
                    b = mq[pickk].pop_front();
                    exp_q.push_back(b[W-1:0]);
                end while (!b[8]);
                ptr = pickk;
            end
        end
    endfunction

    task automatic compare_traffic(input string tag);
        tests++; if (out_q.size() != exp_q.size()) begin fails++; $display("FAIL %s_byte_count: got %0d expected %0d", tag, out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            tests++; if (out_q[i] !== exp_q[i]) begin fails++; $display("FAIL %s_byte[%0d]: got %h expected %h", tag, i, out_q[i], exp_q[i]); end
        end
        tests++; if (grant_log.size() != exp_grants.size()) begin fails++; $display("FAIL %s_grant_count: got %0d expected %0d", tag, grant_log.size(), exp_grants.size()); end
        for (int i = 0; i < grant_log.size() && i < exp_grants.size(); i++) begin
            tests++; if (grant_log[i] != exp_grants[i]) begin fails++; $display("FAIL %s_grant[%0d]: got %0d expected %0d", tag, i, grant_log[i], exp_grants[i]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rv = '1; rl = '0; rd = 32'hA5A5A5A5; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (grant !== '0) begin fails++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        tests++; if (tx_data !== '0) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        rst = 1'b0; rv = '0;
    endtask

    task automatic test_single();
        do_reset();
        rv = 4'b0001; rd = '0; rd[7:0] = 8'h41; rl = '0;
        #1;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_grant_latency: got %b expected 0000", grant); end
        tick();
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b expected 0001", grant); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL single_no_grant_cycle_byte: got %b expected 0", tx_valid); end
        tick();
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL single_beat0: got %b/%h expected 1/41", tx_valid, tx_data); end
        rd[7:0] = 8'h42;
        tick();
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin fails++; $display("FAIL single_beat1: got %b/%h expected 1/42", tx_valid, tx_data); end
        rd[7:0] = 8'h43; rl[0] = 1'b1;
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_before_last: got %b expected 1", busy); end
        tick();
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin fails++; $display("FAIL single_beat2: got %b/%h expected 1/43", tx_valid, tx_data); end
        tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL single_release: busy=%b grant=%b expected 0/0000", busy, grant); end
        rv = '0; rl = '0;
        tick();
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b expected 0", tx_valid); end
    endtask

    task automatic test_round_robin();
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            src_q[k].push_back({1'b0, 8'(k*16 + 1)});
            src_q[k].push_back({1'b1, 8'(k*16 + 2)});
        end
        src_q[0].push_back({1'b0, 8'h05});
        src_q[0].push_back({1'b1, 8'h06});
        build_model();
        run_traffic(500, 1'b0);
        compare_traffic("rr");
        tests++; if (grant_log.size() != 5) begin fails++; $display("FAIL rr_order_len: got %0d expected 5", grant_log.size()); end
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            tests++; if (grant_log[i] != rr_exp[i]) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_log[i], rr_exp[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        rv = 4'b0010; rd = '0; rd[15:8] = 8'h10; rl = '0;
        tick();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL stall_grant: got %b expected 0010", grant); end
        tick();
        tx_ready = 1'b0; rd[15:8] = 8'h11;
        #1;
        for (int i = 0; i < 20; i++) begin
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, req_ready); end
            tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin fails++; $display("FAIL stall_hold[%0d]: got %b/%h expected 1/10", i, tx_valid, tx_data); end
            tests++; if (timeout !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL stall_no_timeout[%0d]: timeout=%b busy=%b expected 0/1", i, timeout, busy); end
            tick();
        end
        tx_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stall_resume_ready: got %b expected 0010", req_ready); end
        tick();
        tests++; if (tx_data !== 8'h11) begin fails++; $display("FAIL stall_next_byte: got %h expected 11", tx_data); end
        rd[15:8] = 8'h12; rl[1] = 1'b1;
        tick();
        rv = '0; rl = '0;
        tests++; if (busy !== 1'b0 || tx_data !== 8'h12) begin fails++; $display("FAIL stall_finish: busy=%b data=%h expected 0/12", busy, tx_data); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        rv = 4'b1100; rd = '0; rd[23:16] = 8'h20; rd[31:24] = 8'h30; rl = 4'b1000;
        tick();
        tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL to_grant: got %b expected 0100", grant); end
        tick();
        rv[2] = 1'b0;
        tests++; if (tx_data !== 8'h20) begin fails++; $display("FAIL to_byte: got %h expected 20", tx_data); end
        for (int i = 1; i < TO; i++) begin
            tick();
            tests++; if (timeout !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL to_early[%0d]: timeout=%b busy=%b expected 0/1", i, timeout, busy); end
        end
        tick();
        tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b expected 1", timeout); end
        tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL to_release: busy=%b grant=%b expected 0/0000", busy, grant); end
        tick();
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_width: got %b expected 0", timeout); end
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL to_next_grant: got %b expected 1000", grant); end
        tick();
        rv = '0; rl = '0;
        tests++; if (tx_data !== 8'h30 || busy !== 1'b0) begin fails++; $display("FAIL to_next_msg: data=%h busy=%b expected 30/0", tx_data, busy); end
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        rv = 4'b0001; rd = '0; rd[7:0] = 8'h50; rl = '0;
        tick();
        tick();
        en = 1'b0; rv = 4'b0011; rd[7:0] = 8'h51; rd[15:8] = 8'h60; rl = 4'b0011;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL en_owner_ready: got %b expected 0001", req_ready); end
        tick();
        rv[0] = 1'b0;
        tests++; if (tx_data !== 8'h51 || busy !== 1'b0) begin fails++; $display("FAIL en_owner_completes: data=%h busy=%b expected 51/0", tx_data, busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL en_blocked[%0d]: got %b expected 0000", i, grant); end
        end
        en = 1'b1;
        tick();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL en_regrant: got %b expected 0010", grant); end
        tick();
        rv = '0; rl = '0;
        tests++; if (tx_data !== 8'h60) begin fails++; $display("FAIL en_second_msg: got %h expected 60", tx_data); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        rv = 4'b0100; rd = '0; rd[23:16] = 8'h70; rl = '0;
        tick();
        tick();
        tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL areset_setup: valid=%b busy=%b expected 1/1", tx_valid, busy); end
        #2 rst = 1'b1;
        #1;
        tests++; if (grant !== '0 || busy !== 1'b0) begin fails++; $display("FAIL areset_state: grant=%b busy=%b expected 0000/0", grant, busy); end
        tests++; if (tx_valid !== 1'b0 || tx_data !== '0) begin fails++; $display("FAIL areset_tx: valid=%b data=%h expected 0/00", tx_valid, tx_data); end
        tests++; if (req_ready !== '0 || timeout !== 1'b0) begin fails++; $display("FAIL areset_misc: ready=%b timeout=%b expected 0000/0", req_ready, timeout); end
        rv = 4'b1111; rl = 4'b1111; rd = 32'h33221100;
        #1 rst = 1'b0; tx_ready = 1'b1;
        tick();
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL areset_priority: got %b expected 0001", grant); end
        tick();
        rv = '0; rl = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int nmsg, len;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                src_q[k].delete();
                nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) src_q[k].push_back({b == len - 1, 8'($urandom)});
                end
            end
            build_model();
            run_traffic(3000, 1'b1);
            compare_traffic("rand");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
